// File: rtl/pipeline_if.sv
// Instruction fetch stage: keeps a fetch request to instruction memory open,
// buffers one returned word while ID is stalled, and handles redirects.
module pipeline_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_tag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] pc_out_nxt;
    logic        valid_nxt;

    logic [31:0] skid_data;
    logic [31:0] skid_pc;
    logic        skid_valid;
    logic [31:0] skid_data_nxt;
    logic [31:0] skid_pc_nxt;
    logic        skid_valid_nxt;

    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        slot_free;
    logic        consumed;

    assign target    = {branch_target[31:2], 2'b00};
    assign pc_inc    = pc + 32'd4;
    assign slot_free = !inst_valid || !stall;
    assign consumed  = inst_valid && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (branch_tag) begin
                    state_nxt = mem_ready ? FETCH : DISCARD;
                end else if (mem_ready && !slot_free) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (branch_tag || !stall) begin
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                if (mem_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req        = (state == FETCH) || (state == DISCARD);
        pc_nxt         = pc;
        addr_nxt       = mem_addr;
        inst_nxt       = inst;
        pc_out_nxt     = pc_out;
        valid_nxt      = inst_valid;
        skid_data_nxt  = skid_data;
        skid_pc_nxt    = skid_pc;
        skid_valid_nxt = skid_valid;

        // A redirect flushes the output slot and skid in every state.
        if (branch_tag) begin
            valid_nxt      = 1'b0;
            inst_nxt       = 32'h0;
            skid_valid_nxt = 1'b0;
            pc_nxt         = target;
        end

        case (state)
            IDLE: begin
                addr_nxt = branch_tag ? target : pc;
            end
            FETCH: begin
                if (branch_tag) begin
                    if (mem_ready) begin
                        addr_nxt = target;
                    end
                end else if (mem_ready) begin
                    if (slot_free) begin
                        inst_nxt   = mem_data;
                        pc_out_nxt = mem_addr;
                        valid_nxt  = 1'b1;
                    end else begin
                        skid_data_nxt  = mem_data;
                        skid_pc_nxt    = mem_addr;
                        skid_valid_nxt = 1'b1;
                    end
                    pc_nxt   = pc_inc;
                    addr_nxt = pc_inc;
                end else if (consumed) begin
                    valid_nxt = 1'b0;
                    inst_nxt  = 32'h0;
                end
            end
            HOLD: begin
                if (branch_tag) begin
                    addr_nxt = target;
                end else if (!stall) begin
                    inst_nxt       = skid_valid ? skid_data : 32'h0;
                    pc_out_nxt     = skid_pc;
                    valid_nxt      = skid_valid;
                    skid_valid_nxt = 1'b0;
                end
            end
            DISCARD: begin
                if (mem_ready) begin
                    addr_nxt = branch_tag ? target : pc;
                end
            end
            default: begin
                addr_nxt = pc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            mem_addr   <= RESET_PC;
            inst       <= 32'h0;
            pc_out     <= 32'h0;
            inst_valid <= 1'b0;
            skid_data  <= 32'h0;
            skid_pc    <= 32'h0;
            skid_valid <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            mem_addr   <= addr_nxt;
            inst       <= inst_nxt;
            pc_out     <= pc_out_nxt;
            inst_valid <= valid_nxt;
            skid_data  <= skid_data_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_valid <= skid_valid_nxt;
        end
    end

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for pipeline_if; memory returns addr+0x100 whenever ready.
module tb_pipeline_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_tag;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign mem_data = mem_addr + 32'h100;

    pipeline_if #(.RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_tag(branch_tag),
        .branch_target(branch_target),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_data(mem_data),
        .inst(inst),
        .pc_out(pc_out),
        .inst_valid(inst_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch_tag = 1'b0;
        branch_target = 32'h0; mem_ready = 1'b1;
        step(); step();
        vectors++;
        if ({mem_req, inst_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_req_valid got %b want 00", {mem_req, inst_valid});
        end
        vectors++;
        if ({mem_addr, inst, pc_out} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_regs got %h want 0", {mem_addr, inst, pc_out});
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        step();
        vectors++;
        if ({mem_req, inst_valid, mem_addr} !== {2'b10, 32'h0}) begin
            miscompares++;
            $display("FAIL first_edge got %b %b %h want 1 0 0", mem_req, inst_valid, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({inst_valid, inst, pc_out, mem_addr} !==
                {1'b1, 32'h100 + 32'(4 * i), 32'(4 * i), 32'(4 * i + 4)}) begin
                miscompares++;
                $display("FAIL stream_%0d got %b %h %h %h", i, inst_valid, inst, pc_out, mem_addr);
            end
        end
    endtask

    task automatic test_stall();
        // Output holds 0x108@8, request pending at 0xC.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({mem_req, inst_valid, inst, pc_out, mem_addr} !==
                {2'b01, 32'h108, 32'h8, 32'h10}) begin
                miscompares++;
                $display("FAIL stall_%0d got %b %b %h %h %h", i, mem_req, inst_valid, inst, pc_out, mem_addr);
            end
        end
        stall = 1'b0;
        step();
        vectors++;
        if ({mem_req, inst_valid, inst, pc_out, mem_addr} !==
            {2'b11, 32'h10C, 32'hC, 32'h10}) begin
            miscompares++;
            $display("FAIL skid_out got %b %b %h %h %h want 1 1 10c c 10", mem_req, inst_valid, inst, pc_out, mem_addr);
        end
        step();
        vectors++;
        if ({inst_valid, inst, pc_out} !== {1'b1, 32'h110, 32'h10}) begin
            miscompares++;
            $display("FAIL after_skid got %b %h %h want 1 110 10", inst_valid, inst, pc_out);
        end
    endtask

    task automatic test_wait_redirect();
        rst = 1'b1; mem_ready = 1'b1;
        step();
        rst = 1'b0;
        step(); step(); step();
        mem_ready = 1'b0;
        step();
        vectors++;
        if ({mem_req, inst_valid, inst, mem_addr} !== {2'b10, 32'h0, 32'h8}) begin
            miscompares++;
            $display("FAIL wait_bubble got %b %b %h %h want 1 0 0 8", mem_req, inst_valid, inst, mem_addr);
        end
        branch_tag = 1'b1; branch_target = 32'h40;
        step();
        vectors++;
        if ({mem_req, inst_valid, inst, mem_addr} !== {2'b10, 32'h0, 32'h8}) begin
            miscompares++;
            $display("FAIL discard_hold got %b %b %h %h want 1 0 0 8", mem_req, inst_valid, inst, mem_addr);
        end
        branch_tag = 1'b0; mem_ready = 1'b1;
        step();
        vectors++;
        if ({mem_req, inst_valid, inst, mem_addr} !== {2'b10, 32'h0, 32'h40}) begin
            miscompares++;
            $display("FAIL discard_drop got %b %b %h %h want 1 0 0 40", mem_req, inst_valid, inst, mem_addr);
        end
        step();
        vectors++;
        if ({inst_valid, inst, pc_out, mem_addr} !== {1'b1, 32'h140, 32'h40, 32'h44}) begin
            miscompares++;
            $display("FAIL target_fetch got %b %h %h %h want 1 140 40 44", inst_valid, inst, pc_out, mem_addr);
        end
    endtask

    task automatic test_redirect_ready();
        branch_tag = 1'b1; branch_target = 32'h43;
        step();
        vectors++;
        if ({mem_req, inst_valid, inst, mem_addr} !== {2'b10, 32'h0, 32'h40}) begin
            miscompares++;
            $display("FAIL redir_ready got %b %b %h %h want 1 0 0 40", mem_req, inst_valid, inst, mem_addr);
        end
        branch_tag = 1'b0;
        step();
        vectors++;
        if ({inst_valid, inst, pc_out} !== {1'b1, 32'h140, 32'h40}) begin
            miscompares++;
            $display("FAIL redir_first got %b %h %h want 1 140 40", inst_valid, inst, pc_out);
        end
    endtask

    task automatic test_wrap();
        branch_tag = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_tag = 1'b0;
        vectors++;
        if ({inst_valid, mem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
            miscompares++;
            $display("FAIL wrap_addr got %b %h want 0 fffffffc", inst_valid, mem_addr);
        end
        step();
        vectors++;
        if ({inst_valid, inst, pc_out, mem_addr} !== {1'b1, 32'hFC, 32'hFFFF_FFFC, 32'h0}) begin
            miscompares++;
            $display("FAIL wrap_word got %b %h %h %h want 1 fc fffffffc 0", inst_valid, inst, pc_out, mem_addr);
        end
        step();
        vectors++;
        if ({inst, pc_out, mem_addr} !== {32'h100, 32'h0, 32'h4}) begin
            miscompares++;
            $display("FAIL wrap_next got %h %h %h want 100 0 4", inst, pc_out, mem_addr);
        end
    endtask

    task automatic test_async_reset();
        step();
        mem_ready = 1'b0;
        step();
        vectors++;
        if ({inst_valid, pc_out, mem_addr} !== {1'b0, 32'h4, 32'h8}) begin
            miscompares++;
            $display("FAIL pre_async got %b %h %h want 0 4 8", inst_valid, pc_out, mem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({mem_req, inst_valid, inst, pc_out, mem_addr} !== 98'h0) begin
            miscompares++;
            $display("FAIL async_reset got %b %b %h %h %h want all 0", mem_req, inst_valid, inst, pc_out, mem_addr);
        end
        mem_ready = 1'b1;
        step();
        vectors++;
        if ({mem_req, inst_valid, mem_addr} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_hold got %b %b %h want 0 0 0", mem_req, inst_valid, mem_addr);
        end
        rst = 1'b0;
        step(); step();
        vectors++;
        if ({inst_valid, inst, pc_out, mem_addr} !== {1'b1, 32'h100, 32'h0, 32'h4}) begin
            miscompares++;
            $display("FAIL restart got %b %h %h %h want 1 100 0 4", inst_valid, inst, pc_out, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_wait_redirect();
        test_redirect_ready();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_if.md
PIPELINE_IF -- requirements
Module: pipeline_if

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 stall  input  1  from the hazard unit; 1 means ID does not consume the current output this cycle.
REQ-005 branch_tag  input  1  redirect request from a later stage.
REQ-006 branch_target  input  32  redirect address.
REQ-007 mem_req  output  1  instruction-memory read request.
REQ-008 mem_addr  output  32  instruction-memory read address.
REQ-009 mem_ready  input  1  mem_data is valid for mem_addr this cycle.
REQ-010 mem_data  input  32  instruction word read from memory.
REQ-011 inst  output  32  instruction to the IF/ID register and the ID-stage decoder.
REQ-012 pc_out  output  32  address of inst.
REQ-013 inst_valid  output  1  inst/pc_out hold a real instruction.

Function
REQ-014 Registers: pc (next address), mem_addr, output slot (inst, pc_out, inst_valid), one skid entry (data and pc), and state from {IDLE, FETCH, HOLD, DISCARD}.
REQ-015 Memory handshake: mem_addr SHALL be stable while mem_req=1 until the edge on which mem_ready=1; a transfer completes on that edge; mem_req SHALL be 1 in FETCH and DISCARD and 0 in IDLE and HOLD.
REQ-016 Slot free at an edge means inst_valid=0 or stall=0; the output is consumed at an edge where inst_valid=1 and stall=0.
REQ-017 IDLE: next state is FETCH unconditionally; mem_addr=pc.
REQ-018 FETCH, mem_ready=1, slot free: inst<=mem_data, pc_out<=mem_addr, inst_valid<=1, pc<=pc+4, mem_addr<=pc+4; state stays FETCH.
REQ-019 FETCH, mem_ready=1, slot not free: skid<=(mem_data, mem_addr), pc<=pc+4, mem_addr<=pc+4; state becomes HOLD.
REQ-020 FETCH or HOLD, no new data, output consumed: inst_valid<=0 and inst<=32'h0 (NOP bubble).
REQ-021 HOLD, stall=0: output slot<=skid with inst_valid=1; state becomes FETCH; stall=1 holds all registers.
REQ-022 Redirect (branch_tag=1) SHALL take priority over stall and mem_ready.
REQ-023 On a redirect: inst_valid<=0, inst<=0, the skid entry is invalidated, and pc<={branch_target[31:2],2'b00}.
REQ-024 Redirect in FETCH with mem_ready=0 SHALL go to DISCARD and keep the old mem_addr; redirect with mem_ready=1, or in HOLD, SHALL go to FETCH with mem_addr<=aligned target, and returned data is dropped.
REQ-025 DISCARD: mem_ready=1 SHALL drop the data, set mem_addr<=pc and go to FETCH; a further redirect SHALL only update pc.
REQ-026 pc arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000.
REQ-027 inst SHALL equal 32'h0 whenever inst_valid=0.
REQ-028 Latency: with memory ready every cycle and no stall, one instruction per cycle; first inst_valid=1 on the second edge after reset release.

Reset
REQ-029 While rst=1, without waiting for clk: state=IDLE, pc=mem_addr=RESET_PC, inst=pc_out=0, inst_valid=0, skid invalid, mem_req=0.
REQ-030 Reset mid-transfer SHALL abandon the outstanding request; data returned afterwards is ignored because mem_req=0 in IDLE.

Verification
REQ-031 Release reset with RESET_PC=0 and memory always ready, returning addr+0x100 -> mem_addr 0,4,8 on consecutive cycles; inst 0x100,0x104,0x108 with pc_out 0,4,8.
REQ-032 stall=1 for 3 cycles while inst_valid=1 and memory ready -> output frozen, one word in the skid, state HOLD, mem_req=0; stall=0 -> skid word output next edge, no loss or duplicate.
REQ-033 Memory wait states of 2 cycles at addr 8, then branch_tag=1 with target 0x40 during the wait -> DISCARD; returned word for 8 dropped; next mem_addr=0x40; inst_valid=0 throughout.
REQ-034 branch_tag=1 and mem_ready=1 in the same cycle, target 0x43 -> data dropped, next mem_addr=0x40, inst=0, inst_valid=0.
REQ-035 pc=32'hFFFF_FFFC with memory ready -> next mem_addr=0; pc_out=32'hFFFF_FFFC for that word.
REQ-036 Assert rst asynchronously mid-cycle during a waited request -> outputs reach reset values before the next clk edge; after release, fetching restarts at RESET_PC.
